// File: rtl/sha256_axi4_lite_master.sv
// AXI4-Lite initiator for the SHA-256 register slave: writes each 512-bit block and CTRL, polls done, then reads the digest.
// Latency: 17 writes + START_GAP + polls per block (+8 reads on the last). blk_ready is low while busy; the digest is held until dig_ready.
module sha256_axi4_lite_master #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int START_GAP  = 4,
  parameter int POLL_LIMIT = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  blk_valid,
  output logic                  blk_ready,
  input  logic [511:0]          blk_data,
  input  logic                  blk_last,
  output logic                  dig_valid,
  input  logic                  dig_ready,
  output logic [255:0]          dig_data,
  output logic                  err,
  output logic                  busy,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  WVALID,
  input  logic                  WREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  BVALID,
  output logic                  BREADY,
  input  logic [1:0]            BRESP,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  RVALID,
  output logic                  RREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP
);

  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = ADDR_WIDTH'(16);
  localparam logic [ADDR_WIDTH-1:0] DIG_ADDR  = ADDR_WIDTH'(17);

  typedef enum logic [3:0] {
    IDLE, WR_MSG, WR_CTRL, GAP, POLL_AR, POLL_R, RD_AR, RD_R, OUT, ERR
  } state_t;

  state_t                  state_q;
  logic [511:0]            msg_q;
  logic                    last_q;
  logic [3:0]              widx_q;
  logic [2:0]              didx_q;
  logic [3:0]              gap_q;
  logic [PW-1:0]           poll_q;
  logic                    awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    blk_ready_q, dig_valid_q, err_q;
  logic [255:0]            dig_q;
  logic                    aw_pend, w_pend;

  // A channel stays pending until its own handshake; AW and W complete independently.
  assign aw_pend = awvalid_q & ~AWREADY;
  assign w_pend  = wvalid_q & ~WREADY;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      msg_q       <= '0;
      last_q      <= 1'b0;
      widx_q      <= '0;
      didx_q      <= '0;
      gap_q       <= '0;
      poll_q      <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      blk_ready_q <= 1'b0;
      dig_valid_q <= 1'b0;
      dig_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (blk_ready_q && blk_valid) begin
            blk_ready_q <= 1'b0;
            msg_q       <= blk_data;
            last_q      <= blk_last;
            widx_q      <= '0;
            awaddr_q    <= '0;
            wdata_q     <= blk_data[511:480];
            awvalid_q   <= 1'b1;
            wvalid_q    <= 1'b1;
            state_q     <= WR_MSG;
          end else begin
            blk_ready_q <= 1'b1;
          end
        end
        WR_MSG, WR_CTRL: begin
          if (!bready_q) begin
            awvalid_q <= aw_pend;
            wvalid_q  <= w_pend;
            if (!aw_pend && !w_pend) bready_q <= 1'b1;
          end else if (BVALID) begin
            bready_q <= 1'b0;
            if (BRESP != 2'b00) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else if (state_q == WR_CTRL) begin
              gap_q   <= 4'(START_GAP);
              poll_q  <= '0;
              state_q <= GAP;
            end else if (widx_q == 4'd15) begin
              awaddr_q  <= CTRL_ADDR;
              wdata_q   <= {{(DATA_WIDTH-2){1'b0}}, 1'b1, last_q};
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_CTRL;
            end else begin
              // The block register shifts so the next word is always at the top.
              widx_q    <= widx_q + 4'd1;
              msg_q     <= {msg_q[479:0], 32'b0};
              awaddr_q  <= awaddr_q + ADDR_WIDTH'(1);
              wdata_q   <= msg_q[479:448];
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_q <= 4'd1) begin
            araddr_q  <= CTRL_ADDR;
            arvalid_q <= 1'b1;
            state_q   <= POLL_AR;
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        POLL_AR, RD_AR: begin
          if (ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= (state_q == POLL_AR) ? POLL_R : RD_R;
          end
        end
        POLL_R: begin
          if (RVALID) begin
            rready_q <= 1'b0;
            if (RRESP != 2'b00 || (!RDATA[2] && poll_q == PW'(POLL_LIMIT - 1))) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else if (RDATA[2]) begin
              if (last_q) begin
                didx_q    <= '0;
                araddr_q  <= DIG_ADDR;
                arvalid_q <= 1'b1;
                state_q   <= RD_AR;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              poll_q    <= poll_q + PW'(1);
              arvalid_q <= 1'b1;
              state_q   <= POLL_AR;
            end
          end
        end
        RD_R: begin
          if (RVALID) begin
            rready_q <= 1'b0;
            if (RRESP != 2'b00) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else begin
              // H0 is read first and ends up in the top slice after eight shifts.
              dig_q <= {dig_q[223:0], RDATA};
              if (didx_q == 3'd7) begin
                dig_valid_q <= 1'b1;
                state_q     <= OUT;
              end else begin
                didx_q    <= didx_q + 3'd1;
                araddr_q  <= araddr_q + ADDR_WIDTH'(1);
                arvalid_q <= 1'b1;
                state_q   <= RD_AR;
              end
            end
          end
        end
        OUT: begin
          if (dig_ready) begin
            dig_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        ERR: begin
          err_q       <= 1'b1;
          awvalid_q   <= 1'b0;
          wvalid_q    <= 1'b0;
          bready_q    <= 1'b0;
          arvalid_q   <= 1'b0;
          rready_q    <= 1'b0;
          blk_ready_q <= 1'b0;
          dig_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign blk_ready = blk_ready_q;
  assign dig_valid = dig_valid_q;
  assign dig_data  = dig_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);
  assign AWVALID   = awvalid_q;
  assign AWADDR    = awaddr_q;
  assign WVALID    = wvalid_q;
  assign WDATA     = wdata_q;
  assign BREADY    = bready_q;
  assign ARVALID   = arvalid_q;
  assign ARADDR    = araddr_q;
  assign RREADY    = rready_q;

endmodule

// File: tb/tb_sha256_axi4_lite_master.sv
// Bench for the SHA-256 AXI4-Lite initiator: a behavioural register slave with a reference SHA-256,
// a per-cycle protocol/digest checker, and directed message vectors.
module tb_sha256_axi4_lite_master;

  logic         ACLK = 1'b0;
  logic         ARESETn = 1'b0;
  logic         blk_valid, blk_ready, blk_last;
  logic [511:0] blk_data;
  logic         dig_valid, dig_ready;
  logic [255:0] dig_data;
  logic         err, busy;
  logic         AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic [4:0]   AWADDR, ARADDR;
  logic [31:0]  WDATA, RDATA;
  logic [1:0]   BRESP, RRESP;

  always #5 ACLK = ~ACLK;

  sha256_axi4_lite_master #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .START_GAP(4), .POLL_LIMIT(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data), .err(err), .busy(busy),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  int vecs = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference SHA-256 ----------------
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] b);
    logic [31:0] w [64];
    logic [31:0] a, bb, c, d, e, f, g, hh, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    {a, bb, c, d, e, f, g, hh} = h;
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + bb, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  // ---------------- behavioural register slave ----------------
  logic [31:0]  sregs [16];
  logic [255:0] s_h;
  bit           s_first = 1'b1, s_last = 1'b0, stuck = 1'b0;
  int           s_zero_left = 0, done_delay = 1, err_addr = -1, aw_dly = 0, w_dly = 0, dig_bad = 0;
  logic [36:0]  act_wr [$], exp_wr [$];
  logic [4:0]   act_rd [$], exp_rd [$];

  task automatic slv_write(input logic [4:0] a, input logic [31:0] d);
    logic [511:0] b;
    act_wr.push_back({a, d});
    if (a < 5'd16) sregs[a[3:0]] = d;
    else if (a == 5'd16 && d[1]) begin
      for (int k = 0; k < 16; k++) b[511-32*k -: 32] = sregs[k];
      s_h = compress(s_first ? IV : s_h, b);
      s_first = d[0];
      s_last = d[0];
      s_zero_left = done_delay;
    end
  endtask

  task automatic slv_read(input logic [4:0] a, output logic [31:0] d);
    act_rd.push_back(a);
    d = '0;
    if (a == 5'd16) begin
      if (!stuck && s_zero_left == 0) d = 32'h4;
      else if (s_zero_left > 0) s_zero_left--;
    end else if (a >= 5'd17 && a <= 5'd24) begin
      if (!s_last) dig_bad++;
      d = s_h[255-32*(int'(a)-17) -: 32];
    end
  endtask

  initial begin : slave
    bit aw_f, w_f, b_f, ar_f, r_f, aw_got, w_got, ar_got;
    logic [4:0] aw_a, ar_a;
    logic [31:0] w_d, rd;
    int aw_cnt, w_cnt;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
    aw_f = 0; w_f = 0; b_f = 0; ar_f = 0; r_f = 0; aw_got = 0; w_got = 0; ar_got = 0;
    aw_a = 0; ar_a = 0; w_d = 0; aw_cnt = 0; w_cnt = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
        aw_f = 0; w_f = 0; b_f = 0; ar_f = 0; r_f = 0; aw_got = 0; w_got = 0; ar_got = 0;
        aw_cnt = 0; w_cnt = 0; s_first = 1; s_last = 0; s_zero_left = 0;
      end else begin
        if (aw_f) aw_got = 1;
        if (w_f) w_got = 1;
        if (b_f) BVALID = 0;
        if (ar_f) ar_got = 1;
        if (r_f) RVALID = 0;
        if (aw_got && w_got && !BVALID) begin
          slv_write(aw_a, w_d);
          BVALID = 1;
          BRESP = (int'(aw_a) == err_addr) ? 2'b10 : 2'b00;
          aw_got = 0; w_got = 0;
        end
        if (ar_got && !RVALID) begin
          slv_read(ar_a, rd);
          RVALID = 1; RDATA = rd; RRESP = 2'b00; ar_got = 0;
        end
        aw_cnt = (AWVALID && !aw_got) ? aw_cnt + 1 : 0;
        w_cnt  = (WVALID && !w_got) ? w_cnt + 1 : 0;
        AWREADY = AWVALID && !aw_got && (aw_cnt > aw_dly);
        WREADY  = WVALID && !w_got && (w_cnt > w_dly);
        ARREADY = ARVALID && !ar_got;
        // Everything sampled here is stable until the next rising edge, where these handshakes fire.
        aw_f = AWVALID && AWREADY; if (aw_f) aw_a = AWADDR;
        w_f  = WVALID && WREADY;   if (w_f) w_d = WDATA;
        b_f  = BVALID && BREADY;
        ar_f = ARVALID && ARREADY; if (ar_f) ar_a = ARADDR;
        r_f  = RVALID && RREADY;
      end
    end
  end

  // ---------------- expected-value model ----------------
  logic [255:0] m_h, exp_dig;
  bit           m_first = 1'b1;

  initial begin : compare
    bit p_awv, p_wv, p_arv, p_digv;
    logic [4:0] p_awa, p_ara;
    logic [31:0] p_wd;
    logic [255:0] p_dig;
    p_awv = 0; p_wv = 0; p_arv = 0; p_digv = 0; p_awa = 0; p_ara = 0; p_wd = 0; p_dig = 0;
    forever begin
      @(posedge ACLK);
      #2;
      if (ARESETn) begin
        if (p_awv && !AWREADY) chk("aw_hold", {AWVALID, AWADDR}, {1'b1, p_awa});
        if (p_wv && !WREADY)   chk("w_hold", {WVALID, WDATA}, {1'b1, p_wd});
        if (p_arv && !ARREADY) chk("ar_hold", {ARVALID, ARADDR}, {1'b1, p_ara});
        if (p_digv && !dig_ready) chk("dig_hold", {dig_valid, dig_data}, {1'b1, p_dig});
        if (dig_valid) chk("digest", dig_data, exp_dig);
        if (err) chk("err_quiet", {AWVALID, WVALID, ARVALID, BREADY, RREADY, blk_ready, dig_valid}, 0);
        p_awv = AWVALID; p_awa = AWADDR; p_wv = WVALID; p_wd = WDATA;
        p_arv = ARVALID; p_ara = ARADDR; p_digv = dig_valid; p_dig = dig_data;
      end else begin
        p_awv = 0; p_wv = 0; p_arv = 0; p_digv = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_block(input logic [511:0] b, input bit last);
    int n;
    for (int k = 0; k < 16; k++) exp_wr.push_back({5'(k), b[511-32*k -: 32]});
    exp_wr.push_back({5'd16, 30'b0, 1'b1, last});
    for (int k = 0; k <= done_delay; k++) exp_rd.push_back(5'd16);
    if (last) for (int j = 0; j < 8; j++) exp_rd.push_back(5'(17 + j));
    m_h = compress(m_first ? IV : m_h, b);
    m_first = last;
    if (last) exp_dig = m_h;
    @(negedge ACLK);
    blk_data = b; blk_last = last; blk_valid = 1;
    n = 0;
    while (!blk_ready && n < 2000) begin @(negedge ACLK); n++; end
    chk("blk_accept", blk_ready, 1);
    @(negedge ACLK);
    blk_valid = 0;
  endtask

  task automatic wait_digest(input string name, input logic [255:0] lit);
    int n;
    n = 0;
    while (!dig_valid && n < 3000) begin @(negedge ACLK); n++; end
    chk({name, "_valid"}, dig_valid, 1);
    chk(name, dig_data, lit);
  endtask

  task automatic wait_err();
    int n;
    n = 0;
    while (!err && n < 1000) begin @(negedge ACLK); n++; end
    chk("err_set", err, 1);
  endtask

  task automatic check_logs(input string name);
    chk({name, "_wr_count"}, act_wr.size(), exp_wr.size());
    for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++) chk({name, "_wr"}, act_wr[i], exp_wr[i]);
    chk({name, "_rd_count"}, act_rd.size(), exp_rd.size());
    for (int i = 0; i < act_rd.size() && i < exp_rd.size(); i++) chk({name, "_rd"}, act_rd[i], exp_rd[i]);
    chk({name, "_early_digest_reads"}, dig_bad, 0);
    act_wr.delete(); exp_wr.delete(); act_rd.delete(); exp_rd.delete();
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESETn = 0;
    repeat (3) @(negedge ACLK);
    ARESETn = 1;
    m_first = 1;
    act_wr.delete(); exp_wr.delete(); act_rd.delete(); exp_rd.delete();
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_ctl"}, {AWVALID, WVALID, BREADY, ARVALID, RREADY, AWADDR, ARADDR, WDATA,
                         blk_ready, dig_valid, err, busy}, 0);
    chk({name, "_dig"}, dig_data, 0);
  endtask

  // ---------------- directed vectors ----------------
  logic [511:0] abc, two1, two2;

  initial begin
    int n;
    blk_valid = 0; blk_last = 0; blk_data = '0; dig_ready = 1;
    abc = '0; abc[511:480] = 32'h61626380; abc[31:0] = 32'h00000018;
    two1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
            32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    two2 = '0; two2[31:0] = 32'h000001c0;

    repeat (3) @(negedge ACLK);
    chk_reset_outs("reset");
    ARESETn = 1;

    // single padded block "abc"
    send_block(abc, 1);
    chk("model_abc", exp_dig, ABC_DIG);
    wait_digest("abc_digest", ABC_DIG);
    repeat (4) @(negedge ACLK);
    chk("abc_idle", {busy, err, blk_ready}, 3'b001);
    check_logs("abc");

    // two-block message, digest held under backpressure
    dig_ready = 0;
    send_block(two1, 0);
    send_block(two2, 1);
    chk("model_two", exp_dig, TWO_DIG);
    wait_digest("two_digest", TWO_DIG);
    repeat (3) @(negedge ACLK);
    chk("two_dig_held", {dig_valid, dig_data}, {1'b1, TWO_DIG});
    dig_ready = 1;
    @(negedge ACLK);
    chk("two_dig_drop", dig_valid, 0);
    check_logs("two");

    // W lags AW, then AW lags W
    aw_dly = 0; w_dly = 3;
    send_block(abc, 1);
    wait_digest("wlag_digest", ABC_DIG);
    check_logs("wlag");
    aw_dly = 3; w_dly = 0;
    send_block(abc, 1);
    wait_digest("awlag_digest", ABC_DIG);
    check_logs("awlag");
    aw_dly = 0;

    // reset while word 9 is on the bus, then a clean block
    send_block(abc, 1);
    n = 0;
    while (!(AWVALID && AWADDR == 5'd9) && n < 500) begin @(negedge ACLK); n++; end
    chk("reach_word9", {AWVALID, AWADDR}, {1'b1, 5'd9});
    ARESETn = 0;
    #1;
    chk_reset_outs("mid_reset");
    repeat (2) @(negedge ACLK);
    ARESETn = 1;
    m_first = 1;
    act_wr.delete(); exp_wr.delete(); act_rd.delete(); exp_rd.delete();
    send_block(abc, 1);
    wait_digest("post_reset_digest", ABC_DIG);
    check_logs("post_reset");

    // error response on message word 5
    err_addr = 5;
    send_block(abc, 1);
    wait_err();
    repeat (20) @(negedge ACLK);
    chk("bresp_err_state", {err, blk_ready, busy}, 3'b101);
    chk("bresp_wr_count", act_wr.size(), 6);
    chk("bresp_rd_count", act_rd.size(), 0);
    err_addr = -1;
    do_reset();
    chk("err_cleared", err, 0);

    // done never rises: POLL_LIMIT reads then error
    stuck = 1;
    send_block(abc, 1);
    wait_err();
    repeat (10) @(negedge ACLK);
    chk("poll_rd_count", act_rd.size(), 8);
    for (int i = 0; i < act_rd.size(); i++) chk("poll_rd_addr", act_rd[i], 5'd16);
    chk("poll_wr_count", act_wr.size(), 17);
    chk("poll_err_state", {err, blk_ready}, 2'b10);
    stuck = 0;
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
